// File: rtl/dvsd_1608d.sv
// rtl/dvsd_1608d.sv - sequential restoring divider, 16-bit dividend by 8-bit divisor
//
// Ports:
//   clock      in   system clock, all state updates on the rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   division request, sampled only while idle
//   dividend   in   [DIVIDEND_W-1:0] numerator, captured when start is accepted
//   divisor    in   [DIVISOR_W-1:0]  denominator, captured when start is accepted
//   busy       out  high while a division is in progress
//   done       out  one-cycle pulse when quotient/remainder are valid
//   quotient   out  [DIVIDEND_W-1:0] registered quotient
//   remainder  out  [DIVISOR_W-1:0]  registered remainder
//   dz         out  divide-by-zero flag
//
// Optional feature macro: DVSD_DIVZERO_DETECT_EN
//   defined   - a zero divisor finishes one edge after acceptance with dz=1
//   undefined - dz tied low, a zero divisor runs the full iteration path

module dvsd_1608d #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dz
);

    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // n_reg holds the unconsumed dividend bits in its upper part and the
    // quotient bits produced so far in its lower part; after DIVIDEND_W
    // shifts it holds the full quotient.
    logic [DIVIDEND_W-1:0] n_reg;
    logic [DIVISOR_W-1:0]  d_reg;
    // The partial remainder is architecturally DIVISOR_W+1 bits wide, but
    // after each restore step it is always below the divisor, so only the
    // low DIVISOR_W bits need storing. The extra bit exists in r_shift.
    logic [DIVISOR_W-1:0]  r_reg;
    logic [CNT_W-1:0]      count;

    logic [DIVISOR_W:0]    r_shift;
    logic [DIVISOR_W-1:0]  r_diff;
    logic [DIVISOR_W-1:0]  r_step;
    logic                  take;
    logic [DIVIDEND_W-1:0] n_step;
    logic                  last_iter;
    logic                  div_zero;

    always_comb begin
        r_shift   = {r_reg, n_reg[DIVIDEND_W-1]};
        take      = (r_shift >= {1'b0, d_reg});
        // When take is set the true difference is below 2**DIVISOR_W,
        // so the truncated subtract is exact.
        r_diff    = r_shift[DIVISOR_W-1:0] - d_reg;
        r_step    = take ? r_diff : r_shift[DIVISOR_W-1:0];
        n_step    = {n_reg[DIVIDEND_W-2:0], take};
        last_iter = (count == LAST_ITER);
    end

`ifdef DVSD_DIVZERO_DETECT_EN
    assign div_zero = (d_reg == '0);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN:  if (div_zero || last_iter) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            n_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (div_zero) begin
                        // n_reg is still the untouched dividend here.
                        quotient  <= '1;
                        remainder <= n_reg[DIVISOR_W-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        n_reg <= n_step;
                        r_reg <= r_step;
                        count <= count + 1'b1;
                        if (last_iter) begin
                            quotient  <= n_step;
                            remainder <= r_step;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DVSD_DIVZERO_DETECT_EN
    // The flag tracks the most recent completion only.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dz <= 1'b0;
        end else if (state == S_RUN) begin
            if (div_zero) begin
                dz <= 1'b1;
            end else if (last_iter) begin
                dz <= 1'b0;
            end
        end
    end
`else
    assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_dvsd_1608d.sv
// tb/tb_dvsd_1608d.sv - self-checking bench for dvsd_1608d

module tb_dvsd_1608d;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dz;

    int n_checks = 0;
    int n_pass   = 0;

    dvsd_1608d #(
        .DIVIDEND_W(16),
        .DIVISOR_W (8)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
    } vec_t;

    vec_t vecs[7];

`ifdef DVSD_DIVZERO_DETECT_EN
    localparam int  ZERO_LAT = 1;
    localparam logic ZERO_DZ = 1'b1;
`else
    localparam int  ZERO_LAT = 16;
    localparam logic ZERO_DZ = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issues one division, waits (bounded) for done, checks latency, busy
    // and the done pulse width, and returns the results seen with done.
    task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int exp_lat,
                          output logic [15:0] q, output logic [7:0] r, output logic z);
        int lat;
        int busy_low;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat      = 0;
        busy_low = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_low++;
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("busy_during_run", busy_low, 0);
        check("busy_at_done", busy, 0);
        q = quotient;
        r = remainder;
        z = dz;
        @(posedge clock);
        #1;
        check("done_width", done, 0);
    endtask

    initial begin
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          pulses;
        int          busy_low;
        logic [15:0] ra;
        logic [7:0]  rb;

        vecs[0] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00};
        vecs[1] = '{16'h03E8, 8'h07, 16'h008E, 8'h06};
        vecs[2] = '{16'h1234, 8'h10, 16'h0123, 8'h04};
        vecs[3] = '{16'h00FF, 8'h03, 16'h0055, 8'h00};
        vecs[4] = '{16'h8000, 8'h02, 16'h4000, 8'h00};
        vecs[5] = '{16'h0000, 8'h01, 16'h0000, 8'h00};
        vecs[6] = '{16'h0001, 8'hFF, 16'h0000, 8'h01};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed table, issued back to back
        for (int i = 0; i < 7; i++) begin
            do_div(vecs[i].a, vecs[i].b, 16, q, r, z);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_dz", i), z, 0);
            check($sformatf("vec%0d_hold_q", i), quotient, vecs[i].q);
        end

        // Second start during RUN is ignored
        @(negedge clock);
        dividend = 16'h00FF;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        pulses   = 0;
        busy_low = 0;
        q = '0;
        r = '1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clock);
            if (c == 5) begin
                start    = 1'b1;
                dividend = 16'h0010;
                divisor  = 8'h02;
            end
            if (c == 7) start = 1'b0;
            @(posedge clock);
            #1;
            if (done) begin
                pulses++;
                q = quotient;
                r = remainder;
            end
            if (c < 16 && !busy) busy_low++;
        end
        check("restart_pulses", pulses, 1);
        check("restart_busy", busy_low, 0);
        check("restart_quotient", q, 16'h0055);
        check("restart_remainder", r, 8'h00);

        // Start during the DONE cycle is ignored
        @(negedge clock);
        dividend = 16'h0064;
        divisor  = 8'h0A;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clock);
            #1;
        end
        check("done_seen_100_10", done, 1);
        check("q_100_10", quotient, 16'h000A);
        @(negedge clock);
        dividend = 16'h0009;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("start_in_done_busy", busy, 0);
        pulses = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (done) pulses++;
        end
        check("start_in_done_pulses", pulses, 0);
        check("start_in_done_hold_q", quotient, 16'h000A);

        // Divide by zero
        do_div(16'h00AB, 8'h00, ZERO_LAT, q, r, z);
        check("dz_quotient", q, 16'hFFFF);
        check("dz_remainder", r, 8'hAB);
        check("dz_flag", z, ZERO_DZ);
        check("dz_hold", dz, ZERO_DZ);
        do_div(16'h0030, 8'h04, 16, q, r, z);
        check("dz_clear_quotient", q, 16'h000C);
        check("dz_clear_flag", z, 0);

        // Reset during iteration 8 aborts the division
        @(negedge clock);
        dividend = 16'h8000;
        divisor  = 8'h02;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dz", dz, 0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (done || busy) pulses++;
        end
        check("abort_no_done", pulses, 0);
        do_div(16'h8000, 8'h02, 16, q, r, z);
        check("after_abort_quotient", q, 16'h4000);
        check("after_abort_remainder", r, 8'h00);

        // Random pairs checked against the division identity
        for (int i = 0; i < 500; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            do_div(ra, rb, 16, q, r, z);
            check($sformatf("rand%0d_identity(%0h/%0h)", i, ra, rb),
                  32'(q) * 32'(rb) + 32'(r), 32'(ra));
            check($sformatf("rand%0d_rem_lt_div", i), (r < rb) ? 1 : 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dvsd_1608d.md
Name: dvsd_1608d

Overview:
- Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor.
- Produces a 16-bit quotient and an 8-bit remainder, one quotient bit per clock.
- Inverse companion to the 8x8->16 multiplier in the dvsd arithmetic set: a multiplier product fed back in with either multiplier operand returns the other operand with zero remainder.
- Start/busy/done handshake toward the surrounding datapath.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width.
- DIVISOR_W, 8, divisor and remainder width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DIVIDEND_W  numerator; captured when start is accepted.
- divisor  input  DIVISOR_W  denominator; captured when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  DIVIDEND_W  registered quotient.
- remainder  output  DIVISOR_W  registered remainder.
- dz  output  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; busy, done, dz=0; quotient, remainder=0; counter and internal registers cleared. Reset overrides every other input, including mid-operation: the division in flight is aborted and no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: capture dividend into shift register N and divisor into D; clear partial remainder R (DIVISOR_W+1 bits); count=0; busy=1; state=RUN.
  - start=0: remain in IDLE.
- RUN, one iteration per edge:
  - R' = {R[DIVISOR_W-1:0], N msb}; N shifts left.
  - If R' >= {1'b0,D}: R = R'-D and shift 1 into the quotient lsb. Otherwise R = R' and shift 0 into the quotient lsb.
  - count increments.
  - Iterations occur at edges k+1 .. k+DIVIDEND_W.
  - At edge k+DIVIDEND_W: quotient/remainder output registers load the final values; busy=0; done=1; state=DONE.
- DONE: at the next edge done=0, state=IDLE. A start in this cycle is ignored.
- Latency: start sampled at edge k -> done high for exactly the cycle following edge k+DIVIDEND_W (17 edges total at defaults). Next start is accepted no earlier than edge k+DIVIDEND_W+2.
- start while busy or done is ignored. dividend and divisor may change freely after acceptance with no effect on the operation in flight.
- quotient, remainder and dz hold their last completed values until the next completion or reset.
- Arithmetic: unsigned. Invariant dividend == quotient*divisor + remainder, with remainder < divisor whenever divisor != 0. The compare/subtract operates on DIVISOR_W+1 bits, so there is no overflow.
- Divisor = 0 without the feature: the algorithm runs normally. Result: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], dz=0.

Optional Feature:
- Macro: DVSD_DIVZERO_DETECT_EN.
- Defined:
  - Start accepted with divisor==0 skips RUN. At edge k+1: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], dz=1, done=1, busy=0, state=DONE.
  - Any completion with nonzero divisor clears dz.
- Undefined: dz tied 0; divisor==0 takes the full DIVIDEND_W-iteration path with the results given above.

Test Plan:
- Reset then start with dividend=0xFFFF, divisor=0xFF -> done after 17 edges; quotient=0x0101, remainder=0x00.
- dividend=1000 (0x03E8), divisor=7 -> quotient=0x008E, remainder=0x06. Back-to-back: dividend=0x1234, divisor=0x10 issued in the cycle after done -> quotient=0x0123, remainder=0x04.
- Start with 0x00FF/0x03; assert start again with 0x0010/0x02 at iteration 5 -> second request ignored; result 0x0055 r 0x00; busy stays high throughout; exactly one done pulse.
- dividend=0x00AB, divisor=0 -> macro defined: done at edge k+1, dz=1, quotient=0xFFFF, remainder=0xAB. Macro undefined: done after 17 edges, dz=0, same quotient/remainder.
- reset_n low for one edge at iteration 8 of 0x8000/0x02 -> all outputs 0, state IDLE, no done. A subsequent 0x8000/0x02 -> quotient=0x4000, remainder=0.
- 500 random {dividend, nonzero divisor} pairs plus 0x0000/0x01 and 0x0001/0xFF -> quotient*divisor+remainder==dividend and remainder<divisor each time; done width exactly 1 cycle.
